alu_result_buffer: RTL and testbench

//  Downstream of the 32-bit ALU: captures each ALU result {Y, ZERO[0], dest reg} into a small FIFO.

---
 rtl/alu_result_buffer_pkg.sv | 28 ++
 rtl/alu_rb_ptr_ctrl.sv | 101 ++++++++++
 rtl/prj_definition.v | 13 +
 rtl/alu_result_buffer.sv | 128 ++++++++++++
 tb/tb_alu_result_buffer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_result_buffer_pkg.sv
// rtl/alu_result_buffer_pkg.sv - shared types and helpers for the ALU result buffer
//
// Provides the datapath width, the push/pop operation encoding used by the
// pointer controller, and the entry-width helper used to size storage.
`include "prj_definition.v"

package alu_result_buffer_pkg;

  localparam int DATA_W = `DATA_WIDTH;

  // Bit 1 = push, bit 0 = pop, so the op can be formed straight from the strobes.
  typedef enum logic [1:0] {
    RB_HOLD = 2'b00,
    RB_POP  = 2'b01,
    RB_PUSH = 2'b10,
    RB_BOTH = 2'b11
  } rb_op_e;

  function automatic rb_op_e rb_op(input logic push, input logic pop);
    return rb_op_e'({push, pop});
  endfunction

  // Entry packing is {ZERO, DST, Y}; this is the single place its width is defined.
  function automatic int entry_width(input int addr_w);
    return 1 + addr_w + DATA_W;
  endfunction

endpackage

// File: rtl/alu_rb_ptr_ctrl.sv
// rtl/alu_rb_ptr_ctrl.sv - pointer, occupancy and push/pop/flush arbitration
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush        : synchronous clear; discards any push/pop in the same cycle
//   in_valid     : producer offers an entry
//   out_ready    : consumer takes the head entry
//   bypass       : entry is being forwarded around storage, so do not write it
//   push         : storage write enable for this cycle (already flush-gated)
//   full, empty  : occupancy flags decoded from the registered count
//   wr_ptr       : current write slot
//   rd_ptr_nxt   : head slot after this edge
//   count        : registered occupancy
//   count_nxt    : occupancy after this edge
module alu_rb_ptr_ctrl
  import alu_result_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             out_ready,
  input  logic             bypass,
  output logic             push,
  output logic             full,
  output logic             empty,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr_nxt,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_req;
  logic             pop_req;

  always_comb begin
    full     = (count_q == CNT_MAX);
    empty    = (count_q == '0);
    // No pass-through when full: a simultaneous pop does not open a slot.
    push_req = in_valid & ~full & ~bypass;
    pop_req  = out_ready & ~empty;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      unique case (rb_op(push_req, pop_req))
        RB_PUSH: begin
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          count_d  = count_q + CNT_ONE;
        end
        RB_POP: begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          count_d  = count_q - CNT_ONE;
        end
        RB_BOTH: begin
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        default: begin
        end
      endcase
    end

    push = push_req & ~flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr     = wr_ptr_q;
  assign rd_ptr_nxt = rd_ptr_d;
  assign count      = count_q;
  assign count_nxt  = count_d;

endmodule

// File: rtl/prj_definition.v
// rtl/prj_definition.v - shared project-wide width macros
//
// DATA_WIDTH           : ALU datapath width
// DATA_INDEX_LIMIT     : MSB index of the ALU datapath
// REG_ADDR_INDEX_LIMIT : MSB index of a register-file address
`ifndef PRJ_DEFINITION_V
`define PRJ_DEFINITION_V

`define DATA_WIDTH           32
`define DATA_INDEX_LIMIT     31
`define REG_ADDR_INDEX_LIMIT 4

`endif

// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - FIFO between the ALU and register-file writeback
//
// Captures {Y, ZERO, DST} per ALU result and presents the oldest one to the
// writeback port over a valid/ready handshake.
// Optional feature macro: ALU_RESULT_BYPASS_EN (zero-latency forward when empty).
//
// Ports:
//   CLK, RST                   : clock, asynchronous active-low reset
//   FLUSH                      : synchronous clear of all entries
//   IN_VALID/IN_READY          : producer handshake (IN_READY = ~FULL)
//   IN_Y, IN_ZERO, IN_DST      : incoming ALU result
//   OUT_VALID/OUT_READY        : writeback handshake
//   OUT_Y, OUT_ZERO, OUT_DST   : head entry
//   COUNT, FULL, EMPTY         : occupancy
`include "prj_definition.v"

module alu_result_buffer
  import alu_result_buffer_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int ADDR_W = `REG_ADDR_INDEX_LIMIT + 1,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     FLUSH,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [`DATA_INDEX_LIMIT:0] IN_Y,
  input  logic                     IN_ZERO,
  input  logic [ADDR_W-1:0]        IN_DST,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [`DATA_INDEX_LIMIT:0] OUT_Y,
  output logic                     OUT_ZERO,
  output logic [ADDR_W-1:0]        OUT_DST,
  output logic [CNT_W-1:0]         COUNT,
  output logic                     FULL,
  output logic                     EMPTY
);

  localparam int ENTRY_W = entry_width(ADDR_W);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] out_entry_q, out_entry_d;
  logic [ENTRY_W-1:0] out_sel;

  logic             push;
  logic             full;
  logic             empty;
  logic             bypass;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  assign in_entry = {IN_ZERO, IN_DST, IN_Y};

`ifdef ALU_RESULT_BYPASS_EN
  // Empty buffer and a consumer ready now: hand the result straight through.
  assign bypass = empty & IN_VALID & OUT_READY & ~FLUSH;
`else
  assign bypass = 1'b0;
`endif

  alu_rb_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .clk        (CLK),
    .rst_n      (RST),
    .flush      (FLUSH),
    .in_valid   (IN_VALID),
    .out_ready  (OUT_READY),
    .bypass     (bypass),
    .push       (push),
    .full       (full),
    .empty      (empty),
    .wr_ptr     (wr_ptr),
    .rd_ptr_nxt (rd_ptr_nxt),
    .count      (count),
    .count_nxt  (count_nxt)
  );

  // Storage is intentionally not reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr] <= in_entry;
    end
  end

  // The head register tracks storage[rd_ptr] one edge ahead so OUT_* is a
  // flop output. When the new head slot is the one being written this edge,
  // its contents are still on the input. When the buffer drains (or is
  // flushed) the register holds, so OUT_* keep the last value presented.
  always_comb begin
    out_entry_d = out_entry_q;
    if (bypass) begin
      out_entry_d = in_entry;
    end else if (count_nxt != '0) begin
      if (push && (rd_ptr_nxt == wr_ptr)) begin
        out_entry_d = in_entry;
      end else begin
        out_entry_d = mem_q[rd_ptr_nxt];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_entry_q <= '0;
    end else begin
      out_entry_q <= out_entry_d;
    end
  end

  assign out_sel   = bypass ? in_entry : out_entry_q;
  assign OUT_Y     = out_sel[DATA_W-1:0];
  assign OUT_DST   = out_sel[DATA_W +: ADDR_W];
  assign OUT_ZERO  = out_sel[ENTRY_W-1];
  assign OUT_VALID = ~empty | bypass;
  assign IN_READY  = ~full;
  assign COUNT     = count;
  assign FULL      = full;
  assign EMPTY     = empty;

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - scoreboard bench for alu_result_buffer
module tb_alu_result_buffer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        FLUSH = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] IN_Y = '0;
  logic        IN_ZERO = 1'b0;
  logic [4:0]  IN_DST = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [31:0] OUT_Y;
  logic        OUT_ZERO;
  logic [4:0]  OUT_DST;
  logic [2:0]  COUNT;
  logic        FULL;
  logic        EMPTY;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [31:0] y;
    logic        zero;
    logic [4:0]  dst;
  } exp_t;

  exp_t exp_q[$];

  always #5 CLK = ~CLK;

  alu_result_buffer dut (
    .CLK       (CLK),
    .RST       (RST),
    .FLUSH     (FLUSH),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_Y      (IN_Y),
    .IN_ZERO   (IN_ZERO),
    .IN_DST    (IN_DST),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_Y     (OUT_Y),
    .OUT_ZERO  (OUT_ZERO),
    .OUT_DST   (OUT_DST),
    .COUNT     (COUNT),
    .FULL      (FULL),
    .EMPTY     (EMPTY)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] y, input logic z,
                       input logic [4:0] d, input logic ordy, input logic acc);
    exp_t e;
    IN_VALID  = v;
    IN_Y      = y;
    IN_ZERO   = z;
    IN_DST    = d;
    OUT_READY = ordy;
    if (acc) begin
      e.y = y; e.zero = z; e.dst = d;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: a handshake completes at the next posedge, so compare the head now.
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (RST && OUT_VALID && OUT_READY) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_output: got Y=0x%0h DST=%0d, required no output", OUT_Y, OUT_DST);
      end else begin
        e = exp_q.pop_front();
        chk("out_y",    OUT_Y,           e.y);
        chk("out_zero", 32'(OUT_ZERO),   32'(e.zero));
        chk("out_dst",  32'(OUT_DST),    32'(e.dst));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: bench did not finish, required completion");
    $fatal(1);
  end

  initial begin : stimulus
    // Reset state
    repeat (2) step();
    chk("rst_count",     32'(COUNT),     0);
    chk("rst_empty",     32'(EMPTY),     1);
    chk("rst_full",      32'(FULL),      0);
    chk("rst_out_valid", 32'(OUT_VALID), 0);
    chk("rst_in_ready",  32'(IN_READY),  1);
    chk("rst_out_y",     OUT_Y,          0);
    chk("rst_out_zero",  32'(OUT_ZERO),  0);
    chk("rst_out_dst",   32'(OUT_DST),   0);
    RST = 1'b1;
    step();

    // 1: fill to full, drop the fifth, drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h11 * (i + 1), 1'b0, 5'(i + 1), 1'b0, 1'b1);
      step();
      if (i == 0) begin
        chk("latency_valid", 32'(OUT_VALID), 1);
        chk("latency_y",     OUT_Y,          32'h11);
      end
    end
    chk("full_count",    32'(COUNT),    4);
    chk("full_flag",     32'(FULL),     1);
    chk("full_in_ready", 32'(IN_READY), 0);
    drive(1'b1, 32'h55, 1'b0, 5'd9, 1'b0, 1'b0);
    step();
    chk("full_drop_count", 32'(COUNT), 4);
    drive(1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
    repeat (4) step();
    chk("drain_empty",     32'(EMPTY),     1);
    chk("drain_count",     32'(COUNT),     0);
    chk("drain_out_valid", 32'(OUT_VALID), 0);
    chk("drain_hold_y",    OUT_Y,          32'h44);
    step();
    chk("empty_hold_y",     OUT_Y,       32'h44);
    chk("empty_hold_count", 32'(COUNT),  0);

    // 2: steady push+pop at COUNT=2, pointers wrap several times
    drive(1'b1, 32'hA0, 1'b0, 5'd0, 1'b0, 1'b1);
    step();
    drive(1'b1, 32'hA1, 1'b1, 5'd1, 1'b0, 1'b1);
    step();
    chk("steady_start_count", 32'(COUNT), 2);
    for (int i = 2; i < 12; i++) begin
      drive(1'b1, 32'hA0 + i, i[0], 5'(i), 1'b1, 1'b1);
      step();
      chk("steady_count", 32'(COUNT), 2);
    end
    drive(1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
    repeat (2) step();
    chk("steady_drain_empty", 32'(EMPTY), 1);

    // 3: zero flag and top register address
    drive(1'b1, 32'h0, 1'b1, 5'd31, 1'b0, 1'b1);
    step();
    chk("zf_valid", 32'(OUT_VALID), 1);
    chk("zf_y",     OUT_Y,          0);
    chk("zf_zero",  32'(OUT_ZERO),  1);
    chk("zf_dst",   32'(OUT_DST),   31);
    drive(1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
    step();
    chk("zf_drain_empty", 32'(EMPTY), 1);

    // 4: flush at COUNT=3 beats a simultaneous push
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hC1 + i, 1'b0, 5'(i), 1'b0, 1'b1);
      step();
    end
    chk("flush_pre_count", 32'(COUNT), 3);
    FLUSH = 1'b1;
    drive(1'b1, 32'h99, 1'b0, 5'd7, 1'b0, 1'b0);
    exp_q.delete();
    step();
    FLUSH = 1'b0;
    IN_VALID = 1'b0;
    chk("flush_empty",     32'(EMPTY),     1);
    chk("flush_count",     32'(COUNT),     0);
    chk("flush_out_valid", 32'(OUT_VALID), 0);
    chk("flush_in_ready",  32'(IN_READY),  1);

    // 5: asynchronous reset mid-drain at COUNT=2
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hE1 + i, 1'b0, 5'(i + 3), 1'b0, 1'b1);
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
    step();
    chk("mid_drain_count", 32'(COUNT), 2);
    #2 RST = 1'b0;
    #1;
    chk("async_rst_valid", 32'(OUT_VALID), 0);
    chk("async_rst_count", 32'(COUNT),     0);
    chk("async_rst_empty", 32'(EMPTY),     1);
    chk("async_rst_out_y", OUT_Y,          0);
    exp_q.delete();
    OUT_READY = 1'b0;
    step();
    RST = 1'b1;
    step();
    chk("post_rst_count", 32'(COUNT), 0);

    // 6: empty buffer, producer and consumer both ready
    drive(1'b1, 32'hDEADBEEF, 1'b0, 5'd3, 1'b1, 1'b1);
    #1;
`ifdef ALU_RESULT_BYPASS_EN
    chk("bypass_valid", 32'(OUT_VALID), 1);
    chk("bypass_y",     OUT_Y,          32'hDEADBEEF);
    chk("bypass_count", 32'(COUNT),     0);
    step();
    drive(1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("bypass_no_write", 32'(COUNT), 0);
    step();
    chk("bypass_empty", 32'(EMPTY), 1);
`else
    chk("no_bypass_valid", 32'(OUT_VALID), 0);
    step();
    chk("late_valid", 32'(OUT_VALID), 1);
    chk("late_y",     OUT_Y,          32'hDEADBEEF);
    chk("late_count", 32'(COUNT),     1);
    drive(1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
    step();
    chk("late_drain_empty", 32'(EMPTY), 1);
`endif

    step();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
